dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 52 +++++
 rtl/dmem_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the three buses that meet at the data-memory arbiter:
//   core side : core_req, core_we, core_addr, core_wdata -> core_rdata, core_stall
//   DMA side  : dma_req, dma_we, dma_addr, dma_wdata     -> dma_gnt, dma_rvalid, dma_rdata
//   memory    : mem_write, mem_addr, mem_data_in          <- mem_data_out
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding SoC (pipeline, DMA engine and data memory)
// ---------------------------------------------------------------------------
interface dmem_arbiter_if;
    // core (memory stage) bus
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_stall;

    // DMA bus
    logic        dma_req;
    logic        dma_we;
    logic [4:0]  dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;

    // single memory port
    logic        mem_write;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_rdata, core_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_write, mem_addr, mem_data_in,
        input  mem_data_out
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_rdata, core_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_write, mem_addr, mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data-memory port between the core memory stage and a DMA
// engine. The core has priority; a DMA requester that has been denied for
// STARVE_LIMIT consecutive cycles is granted once by force, after which the
// core is guaranteed the next conflicting cycle.
// Ports:
//   clk  - single clock, all state on the rising edge
//   rst  - synchronous, active-high reset
//   bus  - dmem_arbiter_if.slave (core, DMA and memory buses)
// Parameter:
//   STARVE_LIMIT - denied DMA cycles before a forced grant, legal 1..7
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    // state
    logic [2:0]  starveCntReg,  starveCntNext;
    logic        forceLockReg,  forceLockNext;
    logic        rvalidReg,     rvalidNext;
    logic [31:0] rdataReg,      rdataNext;

    // arbitration results
    logic        forceDma;
    logic        dmaOwn;
    logic        coreOwn;

    // Only the word-address bits of the core address reach memory.
    logic        unusedCoreAddr;
    assign unusedCoreAddr = ^{bus.core_addr[31:7], bus.core_addr[1:0]};

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            starveCntReg <= 3'd0;
            forceLockReg <= 1'b0;
            rvalidReg    <= 1'b0;
            rdataReg     <= 32'd0;
        end else begin
            starveCntReg <= starveCntNext;
            forceLockReg <= forceLockNext;
            rvalidReg    <= rvalidNext;
            rdataReg     <= rdataNext;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        starveCntNext = starveCntReg;
        forceLockNext = 1'b0;
        rvalidNext    = 1'b0;
        rdataNext     = rdataReg;

        if (dmaOwn) begin
            starveCntNext = 3'd0;
        end else if (bus.dma_req && (starveCntReg < LIMIT)) begin
            starveCntNext = starveCntReg + 3'd1;
        end

        // Lock only follows a grant that actually took the port from the core;
        // an uncontested DMA grant does not cost the core anything.
        forceLockNext = dmaOwn && bus.core_req;

        if (dmaOwn && !bus.dma_we) begin
            rvalidNext = 1'b1;
            rdataNext  = bus.mem_data_out;
        end
    end

    // -----------------------------------------------------------------------
    // Output logic: grant decision and memory port steering
    // -----------------------------------------------------------------------
    always_comb begin
        forceDma = bus.dma_req && (starveCntReg == LIMIT) && !forceLockReg;
        // Nobody owns the port while in reset, so no write can slip through.
        dmaOwn   = !rst && bus.dma_req && (!bus.core_req || forceDma);
        coreOwn  = !rst && bus.core_req && !dmaOwn;

        bus.mem_write   = 1'b0;
        bus.mem_addr    = 5'd0;
        bus.mem_data_in = 32'd0;
        if (dmaOwn) begin
            bus.mem_write   = bus.dma_we;
            bus.mem_addr    = bus.dma_addr;
            bus.mem_data_in = bus.dma_wdata;
        end else if (coreOwn) begin
            bus.mem_write   = bus.core_we;
            bus.mem_addr    = bus.core_addr[6:2];
            bus.mem_data_in = bus.core_wdata;
        end

        bus.dma_gnt    = dmaOwn;
        bus.core_stall = bus.core_req && dmaOwn;
        bus.core_rdata = bus.mem_data_out;
        bus.dma_rvalid = rvalidReg;
        bus.dma_rdata  = rdataReg;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a 32-word asynchronous-read memory
// model attached to the memory port. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    int   passCnt;
    int   totalCnt;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // data memory model
    logic [31:0] mem [32];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    end
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_data_in;
    end
    assign bus.mem_data_out = mem[bus.mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic setIn(input logic creq, input logic cwe, input logic [31:0] caddr,
                         input logic [31:0] cwd, input logic dreq, input logic dwe,
                         input logic [4:0] daddr, input logic [31:0] dwd);
        bus.core_req   = creq;
        bus.core_we    = cwe;
        bus.core_addr  = caddr;
        bus.core_wdata = cwd;
        bus.dma_req    = dreq;
        bus.dma_we     = dwe;
        bus.dma_addr   = daddr;
        bus.dma_wdata  = dwd;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic expG;
        logic prevGnt;
        int   gntCount;

        passCnt  = 0;
        totalCnt = 0;

        // ---- reset with both requesters active ----
        rst = 1'b1;
        setIn(1, 1, 32'h1C, 32'hDEADBEEF, 1, 1, 5'd7, 32'hCAFEF00D);
        @(negedge clk);
        chk("rst_gnt",   bus.dma_gnt,    0);
        chk("rst_stall", bus.core_stall, 0);
        chk("rst_wr",    bus.mem_write,  0);
        nextCycle();
        @(negedge clk);
        chk("rst_rvalid", bus.dma_rvalid, 0);
        chk("rst_rdata",  bus.dma_rdata,  32'd0);
        nextCycle();

        // ---- DMA-only write of addr 3 ----
        rst = 1'b0;
        setIn(0, 0, 0, 0, 1, 1, 5'd3, 32'hA5A5A5A5);
        @(negedge clk);
        chk("dw_gnt",   bus.dma_gnt,     1);
        chk("dw_wr",    bus.mem_write,   1);
        chk("dw_addr",  bus.mem_addr,    3);
        chk("dw_data",  bus.mem_data_in, 32'hA5A5A5A5);
        chk("dw_stall", bus.core_stall,  0);
        nextCycle();

        // ---- DMA-only read of addr 3 ----
        setIn(0, 0, 0, 0, 1, 0, 5'd3, 0);
        @(negedge clk);
        chk("dw_no_rvalid", bus.dma_rvalid, 0);
        chk("dr_gnt",       bus.dma_gnt,    1);
        chk("dr_wr",        bus.mem_write,  0);
        chk("dr_addr",      bus.mem_addr,   3);
        nextCycle();

        // ---- idle: read data returns, port unowned ----
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("dr_rvalid",  bus.dma_rvalid,  1);
        chk("dr_rdata",   bus.dma_rdata,   32'hA5A5A5A5);
        chk("idle_wr",    bus.mem_write,   0);
        chk("idle_addr",  bus.mem_addr,    0);
        chk("idle_wdata", bus.mem_data_in, 32'd0);
        chk("idle_gnt",   bus.dma_gnt,     0);
        nextCycle();

        // ---- core load, no DMA ----
        setIn(1, 0, 32'h0000000C, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("cl_rvalid", bus.dma_rvalid, 0);
        chk("cl_rhold",  bus.dma_rdata,  32'hA5A5A5A5);
        chk("cl_addr",   bus.mem_addr,   3);
        chk("cl_rdata",  bus.core_rdata, 32'hA5A5A5A5);
        chk("cl_gnt",    bus.dma_gnt,    0);
        chk("cl_stall",  bus.core_stall, 0);
        nextCycle();

        // ---- core store to word 5 ----
        setIn(1, 1, 32'h00000014, 32'h12345678, 0, 0, 0, 0);
        @(negedge clk);
        chk("cs_wr",   bus.mem_write,   1);
        chk("cs_addr", bus.mem_addr,    5);
        chk("cs_data", bus.mem_data_in, 32'h12345678);
        nextCycle();

        // ---- continuous conflict: forced DMA grant on cycles 4, 9, 14 ----
        prevGnt  = 1'b0;
        gntCount = 0;
        for (int c = 0; c < 15; c++) begin
            setIn(1, 0, 32'h00000014, 0, 1, 0, 5'd3, 0);
            @(negedge clk);
            expG = (c % 5 == 4);
            chk($sformatf("st_gnt_c%0d", c),   bus.dma_gnt,    expG);
            chk($sformatf("st_stall_c%0d", c), bus.core_stall, expG);
            chk($sformatf("st_addr_c%0d", c),  bus.mem_addr,   expG ? 32'd3 : 32'd5);
            chk($sformatf("st_crd_c%0d", c),   bus.core_rdata, expG ? 32'hA5A5A5A5 : 32'h12345678);
            if (c % 5 == 0 && c > 0) begin
                chk($sformatf("st_rvalid_c%0d", c), bus.dma_rvalid, 1);
                chk($sformatf("st_rdata_c%0d", c),  bus.dma_rdata,  32'hA5A5A5A5);
            end
            chk($sformatf("st_b2b_c%0d", c), prevGnt & bus.dma_gnt, 0);
            prevGnt = bus.dma_gnt;
            if (bus.dma_gnt) gntCount++;
            nextCycle();
        end
        chk("st_gnt_total", gntCount, 3);

        // ---- reset clears a partially-built starvation count ----
        for (int c = 0; c < 3; c++) begin
            setIn(1, 0, 32'h14, 0, 1, 0, 5'd3, 0);
            @(negedge clk);
            chk($sformatf("pre_gnt_c%0d", c), bus.dma_gnt, 0);
            nextCycle();
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rc_gnt",   bus.dma_gnt,    0);
        chk("rc_stall", bus.core_stall, 0);
        nextCycle();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("rc_gnt_c%0d", c), bus.dma_gnt, (c == 4));
            nextCycle();
        end

        // ---- reset in the cycle after a granted DMA read ----
        setIn(0, 0, 0, 0, 1, 0, 5'd5, 0);
        @(negedge clk);
        chk("rr_gnt", bus.dma_gnt, 1);
        nextCycle();
        rst = 1'b1;
        setIn(1, 1, 32'h1C, 32'hDEADBEEF, 1, 1, 5'd7, 32'hCAFEF00D);
        @(negedge clk);
        chk("rr_wr",    bus.mem_write,  0);
        chk("rr_gnt2",  bus.dma_gnt,    0);
        chk("rr_stall", bus.core_stall, 0);
        nextCycle();
        rst = 1'b0;
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rr_rvalid", bus.dma_rvalid, 0);
        chk("rr_rdata",  bus.dma_rdata,  32'd0);
        nextCycle();
        setIn(1, 0, 32'h1C, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rr_nowrite", bus.core_rdata, 32'd0);
        nextCycle();

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
